pipe_data_path: RTL and testbench

Three-stage pipelined, parametrised successor to the single-cycle datapath: register file, immediate extender, ALU, word-addressed data memory and writeback mux, with pipeline registers between read, execute and writeback. Decoded control fields enter through a valid/ready handshake, one instruction per cycle. Operand hazards are resolved by forwarding or stalling. Each retired instruction is reported with its ALU flags and writeback value, so the control unit and bench observe execution without peeking inside.

---
 rtl/pipe_data_path.sv | 195 +++++++++++++++++++
 tb/tb_pipe_data_path.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_data_path.sv
// Three-stage (RD -> EX -> WB) pipelined datapath: register file, extender, ALU, data memory.
// Optional macro DATA_PATH_FWD_EN adds EX->RD and WB->RD operand forwarding.
module pipe_data_path #(
    parameter int WIDTH     = 32,
    parameter int REG_AW    = 5,
    parameter int MEM_DEPTH = 256,
    parameter int IMM_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [REG_AW-1:0]        rs,
    input  logic [REG_AW-1:0]        rt,
    input  logic [REG_AW-1:0]        rd,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [IMM_W-1:0]         imm,
    input  logic                     reg_wr,
    input  logic                     reg_dst,
    input  logic                     alu_src,
    input  logic                     ext_op,
    input  logic                     mem_wr,
    input  logic                     mem_to_reg,
    input  logic [2:0]               alu_ctrl,
    output logic                     out_valid,
    output logic                     zero,
    output logic                     ovflw,
    output logic                     cout,
    output logic                     res_msb,
    output logic                     wb_en,
    output logic [REG_AW-1:0]        wb_reg,
    output logic [WIDTH-1:0]         wb_data
);

    localparam int SH_W   = $clog2(WIDTH);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int NREG   = 2 ** REG_AW;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000, ALU_OR  = 3'b001, ALU_ADD = 3'b010, ALU_SLL = 3'b011,
        ALU_SRL = 3'b100, ALU_NOR = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111
    } alu_op_e;

    logic [WIDTH-1:0]  r_regs [NREG];
    logic [WIDTH-1:0]  r_mem  [MEM_DEPTH];

    logic              r_ex_valid, r_ex_reg_wr, r_ex_mem_wr, r_ex_m2r;
    logic [WIDTH-1:0]  r_ex_a, r_ex_b, r_ex_st;
    logic [SH_W-1:0]   r_ex_sh;
    alu_op_e           r_ex_op;
    logic [REG_AW-1:0] r_ex_dst;

    logic              r_wb_valid, r_wb_we, r_wb_mem_wr, r_wb_m2r;
    logic              r_wb_zero, r_wb_ovflw, r_wb_cout, r_wb_msb;
    logic [WIDTH-1:0]  r_wb_res, r_wb_st;
    logic [REG_AW-1:0] r_wb_dst;

    logic [WIDTH-1:0]  w_ext, w_rs_val, w_rt_val, w_busw, w_alu_res;
    logic [WIDTH:0]    w_sum, w_diff;
    logic [REG_AW-1:0] w_dst;
    logic              w_use_rt, w_ex_wr, w_rs_ex, w_rt_ex, w_rs_wb, w_rt_wb;
    logic              w_stall, w_accept, w_cout, w_ovflw;

    // ---------------- RD stage: decode, hazard detection, operand select
    assign w_ext    = ext_op ? {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm}
                             : {{(WIDTH-IMM_W){1'b0}}, imm};
    assign w_dst    = reg_dst ? rd : rt;
    assign w_use_rt = !alu_src || mem_wr;
    assign w_ex_wr  = r_ex_valid && r_ex_reg_wr && (r_ex_dst != '0);
    assign w_rs_ex  = w_ex_wr && (rs == r_ex_dst);
    assign w_rt_ex  = w_ex_wr && (rt == r_ex_dst);
    assign w_rs_wb  = r_wb_we && (rs == r_wb_dst);
    assign w_rt_wb  = r_wb_we && (rt == r_wb_dst);
    assign w_busw   = r_wb_m2r ? r_mem[r_wb_res[MEM_AW-1:0]] : r_wb_res;

`ifdef DATA_PATH_FWD_EN
    // A load still in EX only has its address; its data appears one cycle later in WB.
    assign w_stall  = in_valid && r_ex_m2r && (w_rs_ex || (w_use_rt && w_rt_ex));
    assign w_rs_val = w_rs_ex ? w_alu_res : (w_rs_wb ? w_busw : r_regs[rs]);
    assign w_rt_val = w_rt_ex ? w_alu_res : (w_rt_wb ? w_busw : r_regs[rt]);
`else
    assign w_stall  = in_valid && (w_rs_ex || w_rs_wb || (w_use_rt && (w_rt_ex || w_rt_wb)));
    assign w_rs_val = r_regs[rs];
    assign w_rt_val = r_regs[rt];
`endif

    assign in_ready = rst_n && !w_stall;
    assign w_accept = in_valid && in_ready;

    // ---------------- EX stage: ALU and flags
    assign w_sum  = {1'b0, r_ex_a} + {1'b0, r_ex_b};
    assign w_diff = {1'b0, r_ex_a} + {1'b0, ~r_ex_b} + {{WIDTH{1'b0}}, 1'b1};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_alu_res = '0;
        w_cout    = 1'b0;
        w_ovflw   = 1'b0;
        case (r_ex_op)
            ALU_AND: w_alu_res = r_ex_a & r_ex_b;
            ALU_OR:  w_alu_res = r_ex_a | r_ex_b;
            ALU_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_cout    = w_sum[WIDTH];
                w_ovflw   = (r_ex_a[WIDTH-1] == r_ex_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != r_ex_a[WIDTH-1]);
            end
            ALU_SLL: w_alu_res = r_ex_b << r_ex_sh;
            ALU_SRL: w_alu_res = r_ex_b >> r_ex_sh;
            ALU_NOR: w_alu_res = ~(r_ex_a | r_ex_b);
            ALU_SUB: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_cout    = w_diff[WIDTH];
                w_ovflw   = (r_ex_a[WIDTH-1] != r_ex_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != r_ex_a[WIDTH-1]);
            end
            ALU_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, $signed(r_ex_a) < $signed(r_ex_b)};
        endcase
    end

    // ---------------- Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_reg_wr <= 1'b0;
            r_ex_mem_wr <= 1'b0;
            r_ex_m2r    <= 1'b0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_ex_st     <= '0;
            r_ex_sh     <= '0;
            r_ex_op     <= ALU_AND;
            r_ex_dst    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_mem_wr <= 1'b0;
            r_wb_m2r    <= 1'b0;
            r_wb_zero   <= 1'b0;
            r_wb_ovflw  <= 1'b0;
            r_wb_cout   <= 1'b0;
            r_wb_msb    <= 1'b0;
            r_wb_res    <= '0;
            r_wb_st     <= '0;
            r_wb_dst    <= '0;
        end else begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_reg_wr <= reg_wr;
                r_ex_mem_wr <= mem_wr;
                r_ex_m2r    <= mem_to_reg;
                r_ex_a      <= w_rs_val;
                r_ex_b      <= alu_src ? w_ext : w_rt_val;
                r_ex_st     <= w_rt_val;
                r_ex_sh     <= shamt;
                r_ex_op     <= alu_op_e'(alu_ctrl);
                r_ex_dst    <= w_dst;
            end
            // Bubbles retire as all-zero so idle cycles show clean outputs.
            r_wb_valid  <= r_ex_valid;
            r_wb_we     <= r_ex_valid && r_ex_reg_wr && (r_ex_dst != '0);
            r_wb_mem_wr <= r_ex_valid && r_ex_mem_wr;
            r_wb_m2r    <= r_ex_valid && r_ex_m2r;
            r_wb_zero   <= r_ex_valid && (w_alu_res == '0);
            r_wb_ovflw  <= r_ex_valid && w_ovflw;
            r_wb_cout   <= r_ex_valid && w_cout;
            r_wb_msb    <= r_ex_valid && w_alu_res[WIDTH-1];
            r_wb_res    <= r_ex_valid ? w_alu_res : '0;
            r_wb_st     <= r_ex_valid ? r_ex_st : '0;
            r_wb_dst    <= r_ex_valid ? r_ex_dst : '0;
        end
    end

    // NOTE: the register file is reset to zero; the data memory is deliberately not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (r_wb_we) begin
            r_regs[r_wb_dst] <= w_busw;
        end
    end

    always_ff @(posedge clk) begin
        if (r_wb_valid && r_wb_mem_wr) r_mem[r_wb_res[MEM_AW-1:0]] <= r_wb_st;
    end

    assign out_valid = r_wb_valid;
    assign zero      = r_wb_zero;
    assign ovflw     = r_wb_ovflw;
    assign cout      = r_wb_cout;
    assign res_msb   = r_wb_msb;
    assign wb_en     = r_wb_we;
    assign wb_reg    = r_wb_dst;
    assign wb_data   = w_busw;

endmodule

// File: tb/tb_pipe_data_path.sv
// Directed self-checking bench for pipe_data_path; stall expectations follow DATA_PATH_FWD_EN.
module tb_pipe_data_path;

    localparam logic [2:0] OP_AND = 3'd0, OP_OR  = 3'd1, OP_ADD = 3'd2, OP_SLL = 3'd3,
                           OP_SRL = 3'd4, OP_NOR = 3'd5, OP_SUB = 3'd6, OP_SLT = 3'd7;
`ifdef DATA_PATH_FWD_EN
    localparam int ST_ALU = 0, ST_LOAD = 1;
`else
    localparam int ST_ALU = 2, ST_LOAD = 2;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic        reg_wr = 0, reg_dst = 0, alu_src = 0, ext_op = 0, mem_wr = 0, mem_to_reg = 0;
    logic [2:0]  alu_ctrl = '0;
    logic        out_valid, zero, ovflw, cout, res_msb, wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    pipe_data_path dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op),
        .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .alu_ctrl(alu_ctrl),
        .out_valid(out_valid), .zero(zero), .ovflw(ovflw), .cout(cout), .res_msb(res_msb),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        z, o, c, m;
    } ret_t;

    int   checks = 0, errors = 0, stalls = 0;
    int   cyc = 0;
    ret_t ret_q[$];
    int   acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (out_valid) ret_q.push_back({32'(cyc), wb_en, wb_reg, wb_data, zero, ovflw, cout, res_msb});

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one instruction from posedge+1 and holds it until accepted.
    task automatic issue(input logic [2:0] op, input logic [4:0] s, t, d, sh, input logic [15:0] im,
                         input logic wr, dst, asrc, ext, mw, m2r);
        int  n = 0;
        bit  acc = 0;
        in_valid = 1; alu_ctrl = op; rs = s; rt = t; rd = d; shamt = sh; imm = im;
        reg_wr = wr; reg_dst = dst; alu_src = asrc; ext_op = ext; mem_wr = mw; mem_to_reg = m2r;
        while (!acc && n < 20) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = 1;
                acc_q.push_back(cyc);
            end else n++;
            @(posedge clk); #1;
        end
        stalls = n;
        if (!acc) begin
            checks++; errors++;
            $error("FAIL issue_timeout: in_ready stayed low for %0d cycles", n);
        end
    endtask

    task automatic rtype(input logic [2:0] op, input logic [4:0] d, s, t);
        issue(op, s, t, d, 5'd0, 16'd0, 1, 1, 0, 0, 0, 0);
    endtask
    task automatic itype(input logic [2:0] op, input logic [4:0] t, s, input logic [15:0] im, input logic ext);
        issue(op, s, t, 5'd0, 5'd0, im, 1, 0, 1, ext, 0, 0);
    endtask
    task automatic shift(input logic [2:0] op, input logic [4:0] d, t, sh);
        issue(op, 5'd0, t, d, sh, 16'd0, 1, 1, 0, 0, 0, 0);
    endtask
    task automatic sw(input logic [4:0] t, s, input logic [15:0] im);
        issue(OP_ADD, s, t, 5'd0, 5'd0, im, 0, 0, 1, 1, 1, 0);
    endtask
    task automatic lw(input logic [4:0] t, s, input logic [15:0] im);
        issue(OP_ADD, s, t, 5'd0, 5'd0, im, 1, 0, 1, 1, 0, 1);
    endtask
    task automatic idle();
        in_valid = 0; reg_wr = 0; mem_wr = 0; mem_to_reg = 0;
    endtask
    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Pops the next retirement and compares it (plus accept-to-retire latency) to expectations.
    task automatic expect_ret(input string tag, input logic en, input logic [4:0] rg,
                              input logic [31:0] data, input logic z, o, c, m);
        int       n = 0;
        ret_t     r;
        logic [7:0] lat;
        while (ret_q.size() == 0 && n < 10) begin
            @(negedge clk); n++;
        end
        if (ret_q.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: no retirement within %0d cycles", tag, n);
        end else begin
            r   = ret_q.pop_front();
            lat = (acc_q.size() != 0) ? 8'(r.cyc - 32'(acc_q.pop_front())) : 8'hFF;
            check(tag, {lat, r.en, r.rg, r.data, r.z, r.o, r.c, r.m},
                       {8'd2, en, rg, data, z, o, c, m});
        end
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_outputs", {out_valid, wb_en, zero, ovflw, cout, res_msb, wb_reg, wb_data}, '0);
        @(posedge clk); #1;
        rst_n = 1;
        #1 check("rst_release_ready", in_ready, 1'b1);

        // Overflow chain: r1=-1, r1=0x7FFFFFFF, r2=r1+1, r3=r2-r2
        itype(OP_ADD, 5'd1, 5'd0, 16'hFFFF, 1);
        shift(OP_SRL, 5'd1, 5'd1, 5'd1);
        check("srl_stall", stalls, ST_ALU);
        itype(OP_ADD, 5'd2, 5'd1, 16'h0001, 1);
        check("addi_stall", stalls, ST_ALU);
        rtype(OP_SUB, 5'd3, 5'd2, 5'd2);
        check("sub_stall", stalls, ST_ALU);
        idle();
        expect_ret("addi_m1",  1, 5'd1, 32'hFFFF_FFFF, 0, 0, 0, 1);
        expect_ret("srl",      1, 5'd1, 32'h7FFF_FFFF, 0, 0, 0, 0);
        expect_ret("addi_ovf", 1, 5'd2, 32'h8000_0000, 0, 1, 0, 1);
        expect_ret("sub_zero", 1, 5'd3, 32'h0000_0000, 1, 0, 1, 0);
        sync();

        // Signed compare and shift left
        itype(OP_ADD, 5'd6, 5'd0, 16'hFFFF, 1);
        itype(OP_ADD, 5'd7, 5'd0, 16'h0001, 1);
        rtype(OP_SLT, 5'd8, 5'd6, 5'd7);
        check("slt_stall", stalls, ST_ALU);
        rtype(OP_SLT, 5'd9, 5'd7, 5'd6);
        shift(OP_SLL, 5'd10, 5'd7, 5'd31);
        idle();
        expect_ret("r6_m1",  1, 5'd6,  32'hFFFF_FFFF, 0, 0, 0, 1);
        expect_ret("r7_one", 1, 5'd7,  32'h0000_0001, 0, 0, 0, 0);
        expect_ret("slt_1",  1, 5'd8,  32'h0000_0001, 0, 0, 0, 0);
        expect_ret("slt_0",  1, 5'd9,  32'h0000_0000, 1, 0, 0, 0);
        expect_ret("sll_31", 1, 5'd10, 32'h8000_0000, 0, 0, 0, 1);
        sync();

        // Stores, loads with address wrap, load-use
        itype(OP_ADD, 5'd11, 5'd0, 16'h1234, 0);
        sw(5'd11, 5'd0, 16'h0408);
        check("sw_fwd_stall", stalls, ST_ALU);
        sw(5'd2, 5'd0, 16'h0404);
        lw(5'd4, 5'd0, 16'h0004);
        rtype(OP_ADD, 5'd5, 5'd4, 5'd4);
        check("load_use_stall", stalls, ST_LOAD);
        lw(5'd12, 5'd0, 16'h0408);
        idle();
        expect_ret("r11",    1, 5'd11, 32'h0000_1234, 0, 0, 0, 0);
        expect_ret("sw_r11", 0, 5'd11, 32'h0000_0408, 0, 0, 0, 0);
        expect_ret("sw_r2",  0, 5'd2,  32'h0000_0404, 0, 0, 0, 0);
        expect_ret("lw_r4",  1, 5'd4,  32'h8000_0000, 0, 0, 0, 0);
        expect_ret("add_r5", 1, 5'd5,  32'h0000_0000, 1, 1, 1, 0);
        expect_ret("lw_r12", 1, 5'd12, 32'h0000_1234, 0, 0, 0, 0);
        sync();

        // r0 writes, zero-extension, logic ops, carry/borrow
        itype(OP_ADD, 5'd0, 5'd0, 16'h0005, 1);
        rtype(OP_OR, 5'd13, 5'd0, 5'd0);
        check("r0_no_stall", stalls, 0);
        itype(OP_OR, 5'd14, 5'd0, 16'hFFFF, 0);
        rtype(OP_AND, 5'd15, 5'd14, 5'd6);
        check("and_stall", stalls, ST_ALU);
        rtype(OP_NOR, 5'd16, 5'd14, 5'd0);
        rtype(OP_ADD, 5'd17, 5'd6, 5'd7);
        rtype(OP_SUB, 5'd18, 5'd7, 5'd6);
        rtype(OP_SUB, 5'd19, 5'd2, 5'd7);
        idle();
        expect_ret("wr_r0",    0, 5'd0,  32'h0000_0005, 0, 0, 0, 0);
        expect_ret("rd_r0",    1, 5'd13, 32'h0000_0000, 1, 0, 0, 0);
        expect_ret("ori_zext", 1, 5'd14, 32'h0000_FFFF, 0, 0, 0, 0);
        expect_ret("and",      1, 5'd15, 32'h0000_FFFF, 0, 0, 0, 0);
        expect_ret("nor",      1, 5'd16, 32'hFFFF_0000, 0, 0, 0, 1);
        expect_ret("add_cy",   1, 5'd17, 32'h0000_0000, 1, 0, 1, 0);
        expect_ret("sub_brw",  1, 5'd18, 32'h0000_0002, 0, 0, 0, 0);
        expect_ret("sub_ovf",  1, 5'd19, 32'h7FFF_FFFF, 0, 1, 1, 0);
        sync();

        // Combined store+load returns the old word; EX forwarding beats WB
        issue(OP_ADD, 5'd0, 5'd7, 5'd20, 5'd0, 16'h0004, 1, 1, 1, 1, 1, 1);
        lw(5'd21, 5'd0, 16'h0004);
        itype(OP_ADD, 5'd22, 5'd0, 16'h0001, 1);
        itype(OP_ADD, 5'd22, 5'd0, 16'h0002, 1);
        rtype(OP_ADD, 5'd23, 5'd22, 5'd0);
        check("prio_stall", stalls, ST_ALU);
        idle();
        expect_ret("swlw_old", 1, 5'd20, 32'h8000_0000, 0, 0, 0, 0);
        expect_ret("lw_new",   1, 5'd21, 32'h0000_0001, 0, 0, 0, 0);
        expect_ret("r22_a",    1, 5'd22, 32'h0000_0001, 0, 0, 0, 0);
        expect_ret("r22_b",    1, 5'd22, 32'h0000_0002, 0, 0, 0, 0);
        expect_ret("ex_prio",  1, 5'd23, 32'h0000_0002, 0, 0, 0, 0);
        sync();

        // Reset with a store and an ALU op in flight
        sw(5'd6, 5'd0, 16'h0004);
        itype(OP_ADD, 5'd24, 5'd0, 16'h0007, 1);
        idle();
        rst_n = 0;
        @(negedge clk);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_valid", {out_valid, wb_en}, 2'b00);
        @(negedge clk);
        check("midrst_no_retire", ret_q.size(), 0);
        acc_q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        #1 check("midrst_release_ready", in_ready, 1'b1);
        for (int i = 1; i < 32; i++) rtype(OP_OR, 5'd0, 5'(i), 5'd0);
        lw(5'd25, 5'd0, 16'h0004);
        idle();
        for (int i = 1; i < 32; i++)
            expect_ret($sformatf("post_rst_r%0d", i), 0, 5'd0, 32'h0, 1, 0, 0, 0);
        expect_ret("mem_kept", 1, 5'd25, 32'h0000_0001, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        check("no_extra_retire", ret_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
